// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: fetch FSM states and the IF/ID pipeline record.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with async reset, hold enable and synchronous clear to a bubble.
// Clear outranks enable so a flush still lands while the stage is stalled.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int           W      = $bits(if_id_t),
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (clr) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one outstanding request to a variable-latency imem, feeding IF/ID.
// A response arriving in cycle N reaches decode in cycle N+1; stalls park the word in a one-entry buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam if_id_t IF_ID_BUBBLE = '{
        instr:    NOP_INSTR,
        pc:       '0,
        pc_plus4: '0,
        valid:    1'b0
    };

    fetch_state_t    state;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pcf_plus4;
    logic [XLEN-1:0] fetch_buf;
    logic            have_instr;
    logic            if_id_en;
    logic            if_id_clr;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    assign pcf_plus4 = pcf + 32'd4;
    assign imem_addr = pcf;

    // A word is ready for decode either straight off the bus or from the stall buffer.
    always_comb begin
        have_instr = ((state == FETCH) && imem_valid) || (state == HOLD);
        if_id_d    = IF_ID_BUBBLE;
        if (have_instr) begin
            if_id_d.instr    = (state == HOLD) ? fetch_buf : imem_rdata;
            if_id_d.pc       = pcf;
            if_id_d.pc_plus4 = pcf_plus4;
            if_id_d.valid    = 1'b1;
        end
    end

    assign if_id_en  = !StallD;
    assign if_id_clr = FlushD | PCSrcE;

    if_id_reg #(
        .W      ($bits(if_id_t)),
        .BUBBLE (IF_ID_BUBBLE)
    ) u_if_id (
        .clk (clk),
        .rst (rst),
        .en  (if_id_en),
        .clr (if_id_clr),
        .d   (if_id_d),
        .q   (if_id_q)
    );

    assign InstrD   = if_id_q.instr;
    assign PCD      = if_id_q.pc;
    assign PCPlus4D = if_id_q.pc_plus4;
    assign ValidD   = if_id_q.valid;

    // PCF only advances once its word has been handed to IF/ID, so a stalled word keeps its PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pcf       <= RESET_PC;
            fetch_buf <= NOP_INSTR;
            imem_req  <= 1'b0;
        end else if (PCSrcE) begin
            pcf <= PCTargetE;
            // An unanswered request must still be drained before the new target is issued.
            if (((state == FETCH) || (state == DRAIN)) && !imem_valid) begin
                state    <= DRAIN;
                imem_req <= 1'b0;
            end else begin
                state    <= FETCH;
                imem_req <= 1'b1;
            end
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_valid) begin
                        if (StallD) begin
                            fetch_buf <= imem_rdata;
                            state     <= HOLD;
                            imem_req  <= 1'b0;
                        end else begin
                            pcf <= pcf_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (!StallD) begin
                        pcf      <= pcf_plus4;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage; drives InstrD, PCD, PCPlus4D.
- Owns the PC and issues one outstanding request at a time to a variable-latency instruction memory.
- Accepts redirects from execute (branch/jump) and stall/flush controls from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into IF/ID on flush or empty slot.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- StallD  in  1  hazard unit: hold IF/ID and PC.
- FlushD  in  1  hazard unit: replace IF/ID content with bubble.
- PCSrcE  in  1  execute: redirect PC to PCTargetE.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  request valid; address held stable while high.
- imem_addr  out  32  fetch address (= PCF).
- imem_rdata  in  32  instruction word, valid when imem_valid=1.
- imem_valid  in  1  one-cycle response strobe; same cycle as request or later.
- InstrD  out  32  instruction to decode.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset values: PCF=RESET_PC, state=BOOT, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0. Reset mid-request: response arriving after reset release while in BOOT is ignored.
- States: BOOT, FETCH, HOLD, DRAIN.
  - BOOT: imem_req=0; next cycle -> FETCH.
  - FETCH: imem_req=1, imem_addr=PCF. On imem_valid: if !StallD, load IF/ID {imem_rdata, PCF, PCF+4, ValidD=1}, PCF<=PCF+4, stay FETCH. If StallD, capture word into buffer, imem_req drops next cycle -> HOLD.
  - HOLD: imem_req=0; when !StallD, move buffer into IF/ID (ValidD=1), PCF<=PCF+4 -> FETCH.
  - DRAIN: imem_req=0; wait for stale response, discard it -> FETCH.
- Redirect (PCSrcE=1) has priority over everything except rst:
  - PCF<=PCTargetE; IF/ID loaded with bubble (implicit flush).
  - In FETCH without imem_valid -> DRAIN.
  - In FETCH with imem_valid -> word discarded -> FETCH.
  - In HOLD -> buffer dropped -> FETCH.
  - In DRAIN: stale response still discarded, new target kept.
- FlushD=1 without PCSrcE: IF/ID <= bubble (InstrD=NOP_INSTR, ValidD=0, PCD/PCPlus4D=0); PC and FSM unaffected. FlushD overrides StallD.
- Stall with no flush: IF/ID holds all fields; PCF holds.
- Not stalled, no instruction available this cycle (waiting, HOLD exit pending, DRAIN, BOOT): IF/ID <= bubble.
- Per-cycle priority: rst > PCSrcE > FlushD > StallD > normal advance.
- Arithmetic: PCF+4 modulo 2^32 (0xFFFF_FFFC+4 = 0); no alignment checking; PCTargetE used verbatim.
- Latency: response in cycle N with no stall -> InstrD valid in cycle N+1. Zero-wait memory sustains 1 instruction/cycle.
- Never more than one outstanding request; imem_addr changes only when imem_req=0 or on the edge after imem_valid.

Decomposition:
- Shared package riscv_pkg: NOP_INSTR constant, XLEN=32, fetch_state_t enum {BOOT, FETCH, HOLD, DRAIN}, struct if_id_t {instr, pc, pc_plus4, valid}.
- Sub-module if_id_reg: async-reset IF/ID register with enable (=!StallD) and synchronous clear (=FlushD|PCSrcE) having priority over enable. Reused later for ID/EX.

Test Plan:
- Reset, zero-wait memory returning addr-based words -> imem_req low one cycle after release; InstrD sequence for PCs 0x0, 0x4, 0x8 on consecutive cycles, ValidD=1, PCPlus4D=PCD+4.
- 3-cycle memory latency -> each request held stable 3 cycles; bubbles (ValidD=0, InstrD=0x00000013) in between; single outstanding request.
- StallD high 2 cycles when response for PC 0x10 arrives -> HOLD; IF/ID frozen; after release InstrD=word@0x10 and next imem_addr=0x14.
- PCSrcE=1, PCTargetE=0x100 while request to 0x20 pending -> DRAIN; stale 0x20 word discarded; next imem_addr=0x100; IF/ID bubble.
- FlushD and StallD together -> bubble loaded, PCF unchanged. PCF=0xFFFFFFFC -> next fetch 0x0.
- Assert rst asynchronously mid-request -> outputs at reset values immediately, before the next clock edge.
